// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file / scoreboard slice.
package regfile_pkg;

   localparam int XLEN_DEF = 32;
   localparam int REG_ZERO = 0;

   // Address width for a register count; never narrower than one bit.
   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: stored value, write-port bypass, hardwired zero.
// Bypass enables arrive already qualified by the parent, so tying them low
// gives a plain registered-view read.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = 32,
   parameter int NWR  = 1,
   parameter int AW   = addr_width(NREG)
) (
   input  logic [AW-1:0]        i_addr,
   input  logic [NREG*XLEN-1:0] i_regs,
   input  logic [NWR*AW-1:0]    i_wr_addr,
   input  logic [NWR*XLEN-1:0]  i_wr_data,
   input  logic [NWR-1:0]       i_wr_en,
   output logic [XLEN-1:0]      o_data
);

   logic w_hit;

   // Select stored word, then let later write ports override; r0 and out-of-range read as zero.
   always_comb begin
      o_data = '0;
      w_hit  = 1'b0;
      for (int r = 0; r < NREG; r++) begin
         if (i_addr == AW'(r)) begin
            w_hit  = 1'b1;
            o_data = i_regs[r*XLEN +: XLEN];
         end
      end
      for (int w = 0; w < NWR; w++) begin
         if (w_hit && i_wr_en[w] && (i_wr_addr[w*AW +: AW] == i_addr))
            o_data = i_wr_data[w*XLEN +: XLEN];
      end
      if (!w_hit || (i_addr == AW'(REG_ZERO)))
         o_data = '0;
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// MIPS GPR file with NRD read / NWR write ports and per-register pending bits
// that stall decode on RAW/WAW hazards against in-flight producers.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int  XLEN   = XLEN_DEF,
   parameter int  NREG   = 32,
   parameter int  NRD    = 2,
   parameter int  NWR    = 1,
   parameter int  BYPASS = 1,
   localparam int AW     = addr_width(NREG)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NRD*AW-1:0]   reg_address,
   output logic [NRD*XLEN-1:0] data_out,
   input  logic [NWR*AW-1:0]   reg_write_address,
   input  logic [NWR*XLEN-1:0] data_wb,
   input  logic [NWR-1:0]      regwrite,
   input  logic                issue_valid,
   input  logic [AW-1:0]       issue_rs,
   input  logic [AW-1:0]       issue_rt,
   input  logic [AW-1:0]       issue_rd,
   output logic                stall,
   output logic [AW:0]         pending_count
);

   localparam bit BYP = (BYPASS != 0);

   logic [NREG*XLEN-1:0] w_regs;
   logic [NWR-1:0]       w_byp_en;
   logic [NREG-1:0]      w_clr;
   logic [NREG-1:0]      w_set;
   logic [NREG-1:0]      w_pend_next;
   logic [NREG-1:0]      r_pend;
   logic [AW:0]          w_cnt_next;
   logic [AW:0]          r_cnt;
   logic                 w_haz_rs;
   logic                 w_haz_rt;
   logic                 w_haz_rd;
   logic                 w_accept;

   // A pending register is not a hazard when its writeback is being forwarded this cycle.
   function automatic logic f_hazard(input logic [AW-1:0]   a,
                                     input logic [NREG-1:0] pend,
                                     input logic [NREG-1:0] clr);
      logic h;
      h = 1'b0;
      for (int r = 1; r < NREG; r++) begin
         if (a == AW'(r))
            h = pend[r] & ~(BYP & clr[r]);
      end
      return h;
   endfunction

   assign w_regs[0 +: XLEN] = '0;

   for (genvar g = 1; g < NREG; g++) begin : g_reg
      logic [XLEN-1:0] r_q;
      // Storage word; a higher-index write port overrides a lower one on the same address.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_q <= '0;
         end else begin
            for (int w = 0; w < NWR; w++) begin
               if (regwrite[w] && (reg_write_address[w*AW +: AW] == AW'(g)))
                  r_q <= data_wb[w*XLEN +: XLEN];
            end
         end
      end
      assign w_regs[g*XLEN +: XLEN] = r_q;
   end

   // Forwarding is suppressed while reset is low so reads stay at zero.
   assign w_byp_en = regwrite & {NWR{reset & BYP}};

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      regfile_read_port #(
         .XLEN (XLEN),
         .NREG (NREG),
         .NWR  (NWR),
         .AW   (AW)
      ) u_rd (
         .i_addr    (reg_address[p*AW +: AW]),
         .i_regs    (w_regs),
         .i_wr_addr (reg_write_address),
         .i_wr_data (data_wb),
         .i_wr_en   (w_byp_en),
         .o_data    (data_out[p*XLEN +: XLEN])
      );
   end

   assign w_haz_rs = f_hazard(issue_rs, r_pend, w_clr);
   assign w_haz_rt = f_hazard(issue_rt, r_pend, w_clr);
   assign w_haz_rd = f_hazard(issue_rd, r_pend, w_clr);
   assign stall    = issue_valid & (w_haz_rs | w_haz_rt | w_haz_rd);
   assign w_accept = issue_valid & ~stall;

   // Writeback clears and accepted-issue sets of pending bits; r0 never goes pending.
   always_comb begin
      w_clr = '0;
      w_set = '0;
      for (int r = 1; r < NREG; r++) begin
         for (int w = 0; w < NWR; w++) begin
            if (regwrite[w] && (reg_write_address[w*AW +: AW] == AW'(r)))
               w_clr[r] = 1'b1;
         end
         if (w_accept && (issue_rd == AW'(r)))
            w_set[r] = 1'b1;
      end
   end

   // Set beats clear: a newly issued producer owns the register.
   assign w_pend_next = w_set | (r_pend & ~w_clr);

   // Population count of the next pending vector so the count tracks the bits exactly.
   always_comb begin
      w_cnt_next = '0;
      for (int r = 0; r < NREG; r++)
         w_cnt_next = w_cnt_next + {{AW{1'b0}}, w_pend_next[r]};
   end

   // Pending bits and their count; reset drops every outstanding producer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend <= '0;
         r_cnt  <= '0;
      end else begin
         r_pend <= w_pend_next;
         r_cnt  <= w_cnt_next;
      end
   end

   assign pending_count = r_cnt;

endmodule
